// File: rtl/controle_comportas_acude.sv
// controle_comportas_acude
//   Reservoir level controller. Debounces the 2-bit level sensor, shows the
//   accepted level as a letter on the 7-segment display, and runs a Moore FSM
//   that drives the inflow pump, the spillway gate and the fault alarm, with a
//   minimum dwell time in FILL/DRAIN.
//
// Parameters
//   STABLE_CYCLES  consecutive identical samples needed to accept a level (>=2)
//   MIN_ON_CYCLES  minimum cycles spent in FILL or DRAIN (>=1)
//
// Ports
//   clk_2     in   system clock
//   reset     in   asynchronous reset, active-high
//   sensor    in   raw level: 00 high, 01 normal, 10 low, 11 defective
//   seg       out  7-segment pattern of the filtered level (A/n/b/d)
//   pump      out  inflow pump on (FILL)
//   spillway  out  spillway gate open (DRAIN)
//   alarm     out  sensor fault alarm (FAULT)
//   state     out  FSM state: 00 NORMAL, 01 FILL, 10 DRAIN, 11 FAULT
module controle_comportas_acude #(
  parameter int STABLE_CYCLES = 4,
  parameter int MIN_ON_CYCLES = 8
) (
  input  logic       clk_2,
  input  logic       reset,
  input  logic [1:0] sensor,
  output logic [7:0] seg,
  output logic       pump,
  output logic       spillway,
  output logic       alarm,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    NORMAL = 2'b00,
    FILL   = 2'b01,
    DRAIN  = 2'b10,
    FAULT  = 2'b11
  } state_t;

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int HW = (MIN_ON_CYCLES > 1) ? $clog2(MIN_ON_CYCLES) : 1;

  localparam logic [CW-1:0] CNT_MAX   = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(MIN_ON_CYCLES - 1);

  logic [1:0]    cand;
  logic [CW-1:0] cnt;
  logic [1:0]    level;
  logic [HW-1:0] hold;
  state_t        state_q;
  state_t        state_d;

  // Level filter: a new code must be seen STABLE_CYCLES times in a row.
  // cnt saturates so a long stable input never re-triggers an update.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      cand  <= 2'b01;
      cnt   <= '0;
      level <= 2'b01;
    end else if (sensor != cand) begin
      cand <= sensor;
      cnt  <= CW'(1);
    end else if (cnt < CNT_MAX) begin
      cnt <= cnt + CW'(1);
      if (cnt == CNT_LAST) begin
        level <= cand;
      end
    end
  end

  // State register and dwell counter. hold is reloaded on entry to
  // FILL/DRAIN and counts down to zero while the FSM stays there.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state_q <= NORMAL;
      hold    <= '0;
    end else begin
      state_q <= state_d;
      if ((state_d == FILL || state_d == DRAIN) && state_d != state_q) begin
        hold <= HOLD_LOAD;
      end else if ((state_q == FILL || state_q == DRAIN) && hold != '0) begin
        hold <= hold - HW'(1);
      end
    end
  end

  // Next state from the registered level only; FILL and DRAIN always pass
  // through NORMAL, and FAULT preempts the dwell time.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      NORMAL: begin
        unique case (level)
          2'b10:   state_d = FILL;
          2'b00:   state_d = DRAIN;
          2'b11:   state_d = FAULT;
          default: state_d = NORMAL;
        endcase
      end
      FILL: begin
        if (level == 2'b11)                       state_d = FAULT;
        else if (hold == '0 && level != 2'b10)    state_d = NORMAL;
      end
      DRAIN: begin
        if (level == 2'b11)                       state_d = FAULT;
        else if (hold == '0 && level != 2'b00)    state_d = NORMAL;
      end
      FAULT: begin
        if (level != 2'b11)                       state_d = NORMAL;
      end
      default: state_d = NORMAL;
    endcase
  end

  always_comb begin
    pump     = (state_q == FILL);
    spillway = (state_q == DRAIN);
    alarm    = (state_q == FAULT);
    state    = state_q;
  end

  always_comb begin
    seg = 8'h54;
    unique case (level)
      2'b00:   seg = 8'h77;
      2'b01:   seg = 8'h54;
      2'b10:   seg = 8'h7C;
      2'b11:   seg = 8'h5E;
      default: seg = 8'h54;
    endcase
  end

endmodule

// File: tb/tb_controle_comportas_acude.sv
module tb_controle_comportas_acude;

  localparam int STABLE = 4;
  localparam int MIN_ON = 8;

  logic       clk_2 = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] sensor = 2'b01;
  logic [7:0] seg;
  logic       pump, spillway, alarm;
  logic [1:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  controle_comportas_acude #(
    .STABLE_CYCLES(STABLE),
    .MIN_ON_CYCLES(MIN_ON)
  ) dut (
    .clk_2   (clk_2),
    .reset   (reset),
    .sensor  (sensor),
    .seg     (seg),
    .pump    (pump),
    .spillway(spillway),
    .alarm   (alarm),
    .state   (state)
  );

  always #5 clk_2 = ~clk_2;

  // Reference model: run-length view of the sensor history and an
  // edge-stamped dwell check for the controller.
  int         m_edge;
  int         m_entry;
  logic [1:0] m_run_val;
  int         m_run_len;
  logic [1:0] m_level;
  logic [1:0] m_state;   // 0 NORMAL, 1 FILL, 2 DRAIN, 3 FAULT

  function automatic void model_reset();
    m_edge    = 0;
    m_entry   = 0;
    m_run_val = 2'b01;
    m_run_len = 0;
    m_level   = 2'b01;
    m_state   = 2'd0;
  endfunction

  function automatic void model_step(input logic [1:0] s);
    logic [1:0] lv;
    lv = m_level;
    m_edge++;
    case (m_state)
      2'd0: begin
        if (lv == 2'b10)      begin m_state = 2'd1; m_entry = m_edge; end
        else if (lv == 2'b00) begin m_state = 2'd2; m_entry = m_edge; end
        else if (lv == 2'b11) m_state = 2'd3;
      end
      2'd1: begin
        if (lv == 2'b11) m_state = 2'd3;
        else if (m_edge - m_entry >= MIN_ON && lv != 2'b10) m_state = 2'd0;
      end
      2'd2: begin
        if (lv == 2'b11) m_state = 2'd3;
        else if (m_edge - m_entry >= MIN_ON && lv != 2'b00) m_state = 2'd0;
      end
      default: if (lv != 2'b11) m_state = 2'd0;
    endcase
    if (m_run_len > 0 && s == m_run_val) m_run_len++;
    else begin
      m_run_val = s;
      m_run_len = 1;
    end
    if (m_run_len == STABLE) m_level = s;
  endfunction

  function automatic logic [12:0] exp_out();
    logic [7:0] sg;
    case (m_level)
      2'b00:   sg = 8'h77;
      2'b01:   sg = 8'h54;
      2'b10:   sg = 8'h7C;
      default: sg = 8'h5E;
    endcase
    return {sg, m_state == 2'd1, m_state == 2'd2, m_state == 2'd3, m_state};
  endfunction

  // Drive one sample, let the edge happen, advance the model, settle.
  task automatic tick(input logic [1:0] s);
    sensor = s;
    @(posedge clk_2);
    model_step(s);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk_2);
    reset  = 1'b1;
    sensor = 2'b01;
    #2;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge clk_2);
    reset = 1'b1;
    #1;
    n_checks++;
    if ({seg, pump, spillway, alarm, state} !== 13'h0a80) begin
      n_fail++;
      $display("FAIL reset_values: got seg=%h p=%b s=%b a=%b st=%b, want seg=54 0 0 0 00",
               seg, pump, spillway, alarm, state);
    end
    #2;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 20; i++) begin
      tick(2'b01);
      n_checks++;
      if ({seg, pump, spillway, alarm, state} !== 13'h0a80) begin
        n_fail++;
        $display("FAIL idle_normal cyc %0d: got %h, want %h", i,
                 {seg, pump, spillway, alarm, state}, 13'h0a80);
      end
    end
  endtask

  task automatic test_low_level();
    int pump_cycles;
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      tick(2'b10);
      n_checks++;
      if ({seg, pump, spillway, alarm, state} !== exp_out()) begin
        n_fail++;
        $display("FAIL low_level edge %0d: got %h, want %h", i,
                 {seg, pump, spillway, alarm, state}, exp_out());
      end
      if (i == 4) begin
        n_checks++;
        if (seg !== 8'h7C || state !== 2'b00) begin
          n_fail++;
          $display("FAIL low_level_latency4: got seg=%h st=%b, want 7c 00", seg, state);
        end
      end
      if (i == 5) begin
        n_checks++;
        if (pump !== 1'b1 || state !== 2'b01) begin
          n_fail++;
          $display("FAIL low_level_latency5: got pump=%b st=%b, want 1 01", pump, state);
        end
      end
    end
    pump_cycles = 1;
    for (int i = 0; i < 15; i++) begin
      tick(2'b01);
      if (pump === 1'b1) pump_cycles++;
      n_checks++;
      if ({seg, pump, spillway, alarm, state} !== exp_out()) begin
        n_fail++;
        $display("FAIL fill_dwell cyc %0d: got %h, want %h", i,
                 {seg, pump, spillway, alarm, state}, exp_out());
      end
    end
    n_checks++;
    if (pump_cycles != MIN_ON) begin
      n_fail++;
      $display("FAIL fill_min_on: got %0d pump cycles, want %0d", pump_cycles, MIN_ON);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      tick(i < STABLE - 1 ? 2'b10 : 2'b01);
      n_checks++;
      if (seg !== 8'h54 || pump !== 1'b0 || state !== 2'b00) begin
        n_fail++;
        $display("FAIL glitch cyc %0d: got seg=%h pump=%b st=%b, want 54 0 00",
                 i, seg, pump, state);
      end
    end
  endtask

  task automatic test_direct_jump();
    do_reset();
    for (int i = 0; i < 5; i++) tick(2'b10);
    for (int i = 0; i < 16; i++) begin
      tick(2'b00);
      n_checks++;
      if ({seg, pump, spillway, alarm, state} !== exp_out() || (pump && spillway)) begin
        n_fail++;
        $display("FAIL direct_jump cyc %0d: got %h, want %h", i,
                 {seg, pump, spillway, alarm, state}, exp_out());
      end
    end
    n_checks++;
    if (spillway !== 1'b1 || state !== 2'b10) begin
      n_fail++;
      $display("FAIL direct_jump_end: got sp=%b st=%b, want 1 10", spillway, state);
    end
  endtask

  task automatic test_fault();
    do_reset();
    for (int i = 0; i < 7; i++) tick(2'b00);   // DRAIN entered at edge 5, hold now 5
    for (int i = 1; i <= 5; i++) tick(2'b11);
    n_checks++;
    if (alarm !== 1'b1 || spillway !== 1'b0 || seg !== 8'h5E || state !== 2'b11) begin
      n_fail++;
      $display("FAIL fault_preempt: got a=%b sp=%b seg=%h st=%b, want 1 0 5e 11",
               alarm, spillway, seg, state);
    end
    for (int i = 1; i <= 5; i++) begin
      tick(2'b01);
      n_checks++;
      if ({seg, pump, spillway, alarm, state} !== exp_out()) begin
        n_fail++;
        $display("FAIL fault_exit edge %0d: got %h, want %h", i,
                 {seg, pump, spillway, alarm, state}, exp_out());
      end
    end
    n_checks++;
    if (alarm !== 1'b0 || state !== 2'b00) begin
      n_fail++;
      $display("FAIL fault_exit_end: got a=%b st=%b, want 0 00", alarm, state);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 7; i++) tick(2'b10);
    n_checks++;
    if (pump !== 1'b1) begin
      n_fail++;
      $display("FAIL async_pre: got pump=%b, want 1", pump);
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({seg, pump, spillway, alarm, state} !== 13'h0a80) begin
      n_fail++;
      $display("FAIL async_reset: got %h, want %h", {seg, pump, spillway, alarm, state}, 13'h0a80);
    end
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    logic [1:0] v;
    int         len;
    do_reset();
    for (int r = 0; r < 60; r++) begin
      v   = 2'($urandom_range(0, 3));
      len = $urandom_range(1, 14);
      for (int k = 0; k < len; k++) begin
        tick(v);
        n_checks++;
        if ({seg, pump, spillway, alarm, state} !== exp_out() || (pump && spillway)) begin
          n_fail++;
          $display("FAIL random run %0d: got %h, want %h", r,
                   {seg, pump, spillway, alarm, state}, exp_out());
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_low_level();
    test_glitch();
    test_direct_jump();
    test_fault();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
